// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline-boundary register with valid/ready, flush, skid and stall counter
//
// Purpose: carries a control bundle and a data bundle across one pipeline
// stage boundary. With SKID=1 a second (skid) entry absorbs the in-flight
// transfer so in_ready can come straight from a flop. With SKID=0 only the
// head register exists and in_ready is combinational from out_ready.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   flush      drop every held entry at the next edge
//   in_valid   upstream entry present
//   in_ready   stage accepts an entry this cycle
//   in_ctrl    upstream control bundle  [CTRL_W]
//   in_data    upstream payload         [DATA_W]
//   out_valid  head entry present
//   out_ready  downstream consumes the head this cycle
//   out_ctrl   head control, zero while out_valid=0
//   out_data   head payload, holds last value while out_valid=0
//   stall_cnt  saturating count of edges with out_valid & !out_ready
//   stall_clr  synchronous clear of stall_cnt
module pipe_stage_reg #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 165,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  // EMPTY: nothing held. ONE: head valid. TWO: head and skid valid.
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_ready_q;
  logic              accept;
  logic              drain;

  assign out_valid = (state != EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  // Skid mode publishes a flopped ready so out_ready never reaches upstream
  // combinationally; single-register mode lets the head be replaced on drain.
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid | out_ready);

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      // Data fields are left as-is; only valid and ctrl are cleared.
      state      <= EMPTY;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (accept && (SKID != 0)) begin
            // Head is stalled: park the newcomer and close the input.
            state      <= TWO;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            in_ready_q <= 1'b0;
          end else if (drain) begin
            state     <= EMPTY;
            main_ctrl <= '0;
          end
        end
        TWO: begin
          if (drain) begin
            state      <= ONE;
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_ctrl  <= '0;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int CTRL_W = 9;
  localparam int DATA_W = 165;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b0;
  logic              stall_clr = 1'b0;

  logic              u1_in_ready, u1_out_valid;
  logic [CTRL_W-1:0] u1_out_ctrl;
  logic [DATA_W-1:0] u1_out_data;
  logic [15:0]       u1_stall_cnt;

  logic              u0_in_ready, u0_out_valid;
  logic [CTRL_W-1:0] u0_out_ctrl;
  logic [DATA_W-1:0] u0_out_data;
  logic [15:0]       u0_stall_cnt;

  logic              uc_in_ready, uc_out_valid;
  logic [CTRL_W-1:0] uc_out_ctrl;
  logic [DATA_W-1:0] uc_out_data;
  logic [3:0]        uc_stall_cnt;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(u1_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(u1_out_valid), .out_ready(out_ready),
    .out_ctrl(u1_out_ctrl), .out_data(u1_out_data), .stall_cnt(u1_stall_cnt), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(u0_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(u0_out_valid), .out_ready(out_ready),
    .out_ctrl(u0_out_ctrl), .out_data(u0_out_data), .stall_cnt(u0_stall_cnt), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(4)) uc (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(uc_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(uc_out_valid), .out_ready(out_ready),
    .out_ctrl(uc_out_ctrl), .out_data(uc_out_data), .stall_cnt(uc_stall_cnt), .stall_clr(stall_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    stall_clr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    in_valid = 1'b1; in_ctrl = 9'h1A5; in_data = 165'h42; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (u1_out_ctrl !== 9'h1A5) $display("FAIL pre_reset_ctrl: got %0h exp 1a5", u1_out_ctrl); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (u1_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0h exp 0", u1_out_valid); else passes++;
    checks++; if (u1_out_ctrl !== 9'h0) $display("FAIL reset_out_ctrl: got %0h exp 0", u1_out_ctrl); else passes++;
    checks++; if (u1_out_data !== 165'h0) $display("FAIL reset_out_data: got %0h exp 0", u1_out_data); else passes++;
    checks++; if (u1_in_ready !== 1'b1) $display("FAIL reset_in_ready_skid: got %0h exp 1", u1_in_ready); else passes++;
    checks++; if (u0_in_ready !== 1'b1) $display("FAIL reset_in_ready_noskid: got %0h exp 1", u0_in_ready); else passes++;
    checks++; if (u1_stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d exp 0", u1_stall_cnt); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(i); in_ctrl = CTRL_W'(i);
      checks++; if (u1_in_ready !== 1'b1) $display("FAIL stream_in_ready_%0d: got %0h exp 1", i, u1_in_ready); else passes++;
      tick();
      checks++; if (u1_out_valid !== 1'b1 || u1_out_data !== DATA_W'(i))
        $display("FAIL stream_out_%0d: got valid %0h data %0h exp valid 1 data %0h", i, u1_out_valid, u1_out_data, i);
      else passes++;
    end
    in_valid = 1'b0;
    tick();
    checks++; if (u1_out_valid !== 1'b0 || u1_out_ctrl !== 9'h0)
      $display("FAIL stream_drain_empty: got valid %0h ctrl %0h exp 0 0", u1_out_valid, u1_out_ctrl);
    else passes++;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; in_data = 165'd1; in_ctrl = 9'd1; out_ready = 1'b0;
    tick();
    in_data = 165'd2; in_ctrl = 9'd2;
    checks++; if (u1_in_ready !== 1'b1) $display("FAIL bp_ready_before: got %0h exp 1", u1_in_ready); else passes++;
    tick();
    in_data = 165'd3; in_ctrl = 9'd3;
    checks++; if (u1_in_ready !== 1'b0) $display("FAIL bp_ready_drop: got %0h exp 0", u1_in_ready); else passes++;
    tick();
    checks++; if (u1_out_data !== 165'd1 || u1_in_ready !== 1'b0)
      $display("FAIL bp_hold: got data %0h ready %0h exp 1 0", u1_out_data, u1_in_ready);
    else passes++;
    tick();
    checks++; if (u1_stall_cnt !== 16'd3) $display("FAIL bp_stall_cnt: got %0d exp 3", u1_stall_cnt); else passes++;
    out_ready = 1'b1;
    tick();
    checks++; if (u1_out_data !== 165'd2 || u1_out_valid !== 1'b1)
      $display("FAIL bp_second: got data %0h valid %0h exp 2 1", u1_out_data, u1_out_valid);
    else passes++;
    checks++; if (u1_in_ready !== 1'b1) $display("FAIL bp_ready_reopen: got %0h exp 1", u1_in_ready); else passes++;
    tick();
    in_valid = 1'b0;
    checks++; if (u1_out_data !== 165'd3 || u1_out_ctrl !== 9'd3)
      $display("FAIL bp_third: got data %0h ctrl %0h exp 3 3", u1_out_data, u1_out_ctrl);
    else passes++;
    tick();
    checks++; if (u1_out_valid !== 1'b0) $display("FAIL bp_empty: got %0h exp 0", u1_out_valid); else passes++;
    checks++; if (u1_stall_cnt !== 16'd3) $display("FAIL bp_stall_final: got %0d exp 3", u1_stall_cnt); else passes++;
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_ctrl = 9'h0FF; in_data = 165'd10; out_ready = 1'b0;
    tick();
    in_data = 165'd11;
    tick();
    checks++; if (u1_in_ready !== 1'b0 || u1_out_ctrl !== 9'h0FF)
      $display("FAIL flush_pre_two: got ready %0h ctrl %0h exp 0 ff", u1_in_ready, u1_out_ctrl);
    else passes++;
    flush = 1'b1; in_ctrl = 9'h055; in_data = 165'd99;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (u1_out_valid !== 1'b0) $display("FAIL flush_out_valid: got %0h exp 0", u1_out_valid); else passes++;
    checks++; if (u1_out_ctrl !== 9'h0) $display("FAIL flush_out_ctrl: got %0h exp 0", u1_out_ctrl); else passes++;
    checks++; if (u1_in_ready !== 1'b1) $display("FAIL flush_in_ready: got %0h exp 1", u1_in_ready); else passes++;
    checks++; if (u1_stall_cnt !== 16'd2) $display("FAIL flush_stall_cnt: got %0d exp 2", u1_stall_cnt); else passes++;
    out_ready = 1'b1;
    tick();
    checks++; if (u1_out_valid !== 1'b0) $display("FAIL flush_dropped_entry: got valid %0h exp 0", u1_out_valid); else passes++;
    // Single-register mode: flush on a cycle where an entry is acceptable drops it.
    in_valid = 1'b1; in_ctrl = 9'h011; in_data = 165'd7;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (u0_out_valid !== 1'b0 || u0_out_ctrl !== 9'h0)
      $display("FAIL flush_noskid_drop: got valid %0h ctrl %0h exp 0 0", u0_out_valid, u0_out_ctrl);
    else passes++;
  endtask

  task automatic test_noskid();
    do_reset();
    in_valid = 1'b1; in_ctrl = 9'd3; in_data = 165'd5; out_ready = 1'b0;
    tick();
    in_ctrl = 9'd4; in_data = 165'd6;
    #1;
    checks++; if (u0_in_ready !== 1'b0) $display("FAIL noskid_ready_full: got %0h exp 0", u0_in_ready); else passes++;
    out_ready = 1'b1;
    #1;
    checks++; if (u0_in_ready !== 1'b1) $display("FAIL noskid_ready_comb: got %0h exp 1", u0_in_ready); else passes++;
    tick();
    in_valid = 1'b0;
    checks++; if (u0_out_valid !== 1'b1 || u0_out_data !== 165'd6 || u0_out_ctrl !== 9'd4)
      $display("FAIL noskid_replace: got valid %0h data %0h ctrl %0h exp 1 6 4", u0_out_valid, u0_out_data, u0_out_ctrl);
    else passes++;
    tick();
    checks++; if (u0_out_valid !== 1'b0 || u0_out_ctrl !== 9'h0 || u0_out_data !== 165'd6)
      $display("FAIL noskid_drain: got valid %0h ctrl %0h data %0h exp 0 0 6", u0_out_valid, u0_out_ctrl, u0_out_data);
    else passes++;
  endtask

  task automatic test_counter();
    do_reset();
    in_valid = 1'b1; in_ctrl = 9'd1; in_data = 165'd1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    checks++; if (uc_stall_cnt !== 4'd14) $display("FAIL cnt_14: got %0d exp 14", uc_stall_cnt); else passes++;
    repeat (6) tick();
    checks++; if (uc_stall_cnt !== 4'd15) $display("FAIL cnt_saturate: got %0d exp 15", uc_stall_cnt); else passes++;
    checks++; if (u1_stall_cnt !== 16'd20) $display("FAIL cnt_wide_20: got %0d exp 20", u1_stall_cnt); else passes++;
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    checks++; if (uc_stall_cnt !== 4'd0) $display("FAIL cnt_clear: got %0d exp 0", uc_stall_cnt); else passes++;
    tick();
    checks++; if (uc_stall_cnt !== 4'd1) $display("FAIL cnt_after_clear: got %0d exp 1", uc_stall_cnt); else passes++;
    flush = 1'b1; stall_clr = 1'b1;
    tick();
    flush = 1'b0; stall_clr = 1'b0;
    checks++; if (uc_stall_cnt !== 4'd0 || uc_out_valid !== 1'b0)
      $display("FAIL cnt_flush_clr: got cnt %0d valid %0h exp 0 0", uc_stall_cnt, uc_out_valid);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_noskid();
    test_counter();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-boundary register, the general successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle across one stage boundary with a valid/ready handshake, stall and flush. An optional 2-entry skid mode registers the upstream ready path. A saturating stall counter supports performance observation. One instance sits between each pair of pipeline stages.

## Interface
- CTRL_W, 9: control-bundle width (WB+M style bits); zeroed whenever the stage holds a bubble.
- DATA_W, 165: payload width (ALU result, store data, branch/jump targets, PC, dest reg, flags).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: stall-counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discards every held entry at the next edge.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage accepts an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes the head this cycle.
- out_ctrl  out  CTRL_W  head control; all zeros when out_valid=0.
- out_data  out  DATA_W  head payload; holds its last value when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Storage: main register (the head, drives out_*) and, when SKID=1, a skid register. Each has a valid bit.
- SKID=1 states: EMPTY, ONE (main valid), TWO (main and skid valid).
  - EMPTY: accept -> ONE; main <- input.
  - ONE: accept & drain -> ONE, main <- input. Accept & !drain -> TWO, skid <- input. !accept & drain -> EMPTY. Otherwise hold.
  - TWO: in_ready=0, so no accept. Drain -> ONE, main <- skid. Otherwise hold.
  - in_ready = !skid_valid, driven from a register (no combinational path from out_ready).
- SKID=0: no skid register.
  - in_ready = !out_valid | out_ready (combinational).
  - Accept loads main; drain without accept -> EMPTY.
- Bubble rule: any register whose valid bit clears has its ctrl field cleared in the same edge. out_ctrl is therefore 0 whenever out_valid=0. Data fields are not cleared.
- flush: has priority over accept and drain.
  - Next edge: all valid bits 0, all ctrl 0, state EMPTY, in_ready=1.
  - An entry offered on the flush cycle is dropped.
  - stall_cnt is unaffected.
- stall_cnt: +1 on each edge where out_valid & !out_ready, saturating at 2^CNT_W-1. stall_clr forces 0 and has priority over the increment.
- Ordering is strict FIFO. No entry is duplicated or reordered.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N (1 cycle).
- Throughput: 1 entry/cycle sustained while out_ready=1, in both modes.
- SKID=1: after a single out_ready=0 cycle with continuous input, in_ready drops 1 cycle later. The extra entry lands in skid, with no loss.
- Reset (asynchronous, immediate on rst rising):
  - out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, state EMPTY.
  - in_ready=1 (both modes).
  - Skid contents=0.
- rst mid-operation discards all held entries. The first accept is possible on the first edge after rst deasserts.
- Simultaneous flush & stall_clr: both take effect.
- Simultaneous accept & drain in TWO cannot occur, because in_ready=0.

## Test plan
- Reset: assert rst mid-stream with main=ctrl 0x1A5, data 0x..42 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0, all without a clock edge.
- Streaming: SKID=1, out_ready=1, 8 back-to-back entries data=1..8 -> outputs 1..8 on consecutive cycles, each 1 cycle after input, and in_ready stays 1.
- Backpressure: SKID=1, feed 1,2,3; out_ready=0 for 3 cycles after entry 1 is at the head. Expected:
  - entry 2 goes to skid;
  - in_ready=0 from the next cycle, so entry 3 is held upstream;
  - releasing gives order 1,2,3 with no loss;
  - stall_cnt=3.
- Flush: SKID=1 in TWO with ctrl 0x0FF, plus flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the offered entry never appears.
- SKID=0 mode: out_ready=0 with main full -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> main replaced in 1 edge, out_valid stays 1.
- Counter: CNT_W=4, hold stall for 20 cycles -> stall_cnt saturates at 15. stall_clr -> 0 on the next edge even while still stalled.
